apb_master_transfer_fsm: RTL and testbench

- Synthesizable APB4 requester: converts a valid/ready request into one APB transfer and returns a valid/ready response.
- Sits directly upstream of the slave driver BFM and drives the APB pins that the slave side samples and answers.
- Used as the HDL-side stimulus source for slave-agent bring-up without the HVL master agent.
- Provides wait-state handling, a PREADY timeout, and slave-select decoding.

---
 rtl/apb_master_transfer_fsm_if.sv | 57 +++++
 rtl/apb_master_transfer_fsm.sv | 141 ++++++++++++++
 tb/tb_apb_master_transfer_fsm.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_transfer_fsm_if.sv
// Request/response handshake and APB pin bundle for the APB4 transfer FSM.
// The master modport is the requester's view; the slave modport is the view of the stimulus/BFM side.
interface apb_master_transfer_fsm_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NO_OF_SLAVES = 1
);
    localparam int SEL_W  = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    // request channel
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_write;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [STRB_W-1:0]       req_strb;
    logic [2:0]              req_prot;
    logic [SEL_W-1:0]        req_sel;

    // response channel
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_slverr;
    logic                    rsp_timeout;

    // APB pins
    logic [NO_OF_SLAVES-1:0] psel;
    logic                    penable;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [STRB_W-1:0]       pstrb;
    logic [2:0]              pprot;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot, req_sel,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  rsp_ready,
        output psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot, req_sel,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output rsp_ready,
        input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_master_transfer_fsm.sv
// APB4 requester: turns one accepted valid/ready request into one APB transfer
// (with wait states, PREADY timeout and slave-select decode) and returns a held response.
module apb_master_transfer_fsm #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NO_OF_SLAVES   = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    apb_master_transfer_fsm_if.master bus
);
    localparam int SEL_W  = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } rsp_t;

    state_t                  state;
    rsp_t                    rsp_q;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    req_ready_q;
    logic [NO_OF_SLAVES-1:0] psel_q;
    logic                    penable_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic                    pwrite_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRB_W-1:0]       pstrb_q;
    logic [2:0]              pprot_q;

    logic sel_ok;
    logic accept;
    logic timeout_hit;

    assign sel_ok      = int'(bus.req_sel) < NO_OF_SLAVES;
    assign accept      = bus.req_valid && req_ready_q;
    // pready has priority: a completion in the last allowed cycle is not an abort
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= IDLE;
            rsp_q       <= '0;
            wait_cnt    <= '0;
            req_ready_q <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        paddr_q     <= bus.req_addr;
                        pwrite_q    <= bus.req_write;
                        pprot_q     <= bus.req_prot;
                        if (sel_ok) begin
                            state    <= SETUP;
                            psel_q   <= NO_OF_SLAVES'(1) << bus.req_sel;
                            pwdata_q <= bus.req_write ? bus.req_wdata : '0;
                            pstrb_q  <= bus.req_write ? bus.req_strb  : '0;
                        end else begin
                            // undecodable target: error straight back, bus untouched
                            state <= RESP;
                            rsp_q <= '{valid: 1'b1, rdata: '0, slverr: 1'b1, timeout: 1'b0};
                        end
                    end
                end

                SETUP: begin
                    state     <= ACCESS;
                    penable_q <= 1'b1;
                    wait_cnt  <= '0;
                end

                ACCESS: begin
                    if (bus.pready) begin
                        state     <= RESP;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pwdata_q  <= '0;
                        pstrb_q   <= '0;
                        rsp_q     <= '{valid:   1'b1,
                                       rdata:   (!pwrite_q && !bus.pslverr) ? bus.prdata : '0,
                                       slverr:  bus.pslverr,
                                       timeout: 1'b0};
                    end else if (timeout_hit) begin
                        state     <= RESP;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pwdata_q  <= '0;
                        pstrb_q   <= '0;
                        rsp_q     <= '{valid: 1'b1, rdata: '0, slverr: 1'b1, timeout: 1'b1};
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_q       <= '0;
                        req_ready_q <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_q.valid;
    assign bus.rsp_rdata   = rsp_q.rdata;
    assign bus.rsp_slverr  = rsp_q.slverr;
    assign bus.rsp_timeout = rsp_q.timeout;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.pprot       = pprot_q;
endmodule

// File: tb/tb_apb_master_transfer_fsm.sv
// Scoreboard bench for apb_master_transfer_fsm: a reference model predicts each response
// from the request and the planned slave behaviour; a negedge monitor plays slave and checks.
module tb_apb_master_transfer_fsm;
    localparam int AW = 32, DW = 32, NSLV = 3, TO = 16, SW = 2;

    logic pclk = 1'b0;
    logic preset;
    always #5 pclk = ~pclk;

    apb_master_transfer_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_OF_SLAVES(NSLV)) bus ();

    apb_master_transfer_fsm #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_OF_SLAVES(NSLV), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .preset(preset), .bus(bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        logic [2:0]    prot;
        logic [SW-1:0] sel;
        int            waits;   // cycles the slave holds pready low
        logic          err;
        logic [DW-1:0] rdata;
    } txn_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          slverr;
        logic          timeout;
    } rsp_t;

    typedef struct {
        rsp_t r;
        int   due;
    } exp_t;

    txn_t bus_q[$];
    exp_t exp_q[$];
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0;
    int   rr_mode = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit sel_valid(txn_t t);
        return int'(t.sel) < NSLV;
    endfunction

    function automatic rsp_t model_rsp(txn_t t);
        rsp_t r;
        if (!sel_valid(t))        r = '{rdata: '0, slverr: 1'b1, timeout: 1'b0};
        else if (t.waits >= TO)   r = '{rdata: '0, slverr: 1'b1, timeout: 1'b1};
        else r = '{rdata: (!t.write && !t.err) ? t.rdata : '0, slverr: t.err, timeout: 1'b0};
        return r;
    endfunction

    // cycles from acceptance edge to the edge that raises rsp_valid
    function automatic int model_lat(txn_t t);
        if (!sel_valid(t)) return 0;
        if (t.waits >= TO) return 1 + TO;
        return 2 + t.waits;
    endfunction

    function automatic int access_len(txn_t t);
        return (t.waits >= TO) ? TO : t.waits + 1;
    endfunction

    // response-ready driver
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            case (rr_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = ($urandom % 3) != 0;
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // slave model + bus and response monitor
    initial begin
        txn_t            cur;
        rsp_t            snap;
        exp_t            e;
        bit              in_xfer, rsp_new;
        int              acc_k;
        logic [NSLV-1:0] oh;
        in_xfer = 0; rsp_new = 1; acc_k = 0;
        cur = '{default: '0};
        bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
        forever begin
            @(negedge pclk);
            if (preset) begin
                in_xfer = 0; rsp_new = 1; acc_k = 0;
                continue;
            end
            bus.pready  = 1'($urandom);
            bus.prdata  = $urandom;
            bus.pslverr = 1'($urandom);
            if (|bus.psel) begin
                if (!bus.penable) begin
                    if (in_xfer) chk("setup_one_cycle", 1, 0);
                    if (bus_q.size() == 0) chk("unexpected_psel", bus.psel, 0);
                    else cur = bus_q.pop_front();
                    oh = '0; oh[cur.sel] = 1'b1;
                    chk("setup_pins", {bus.psel, bus.paddr, bus.pwrite, bus.pprot, bus.pwdata, bus.pstrb},
                        {oh, cur.addr, cur.write, cur.prot,
                         cur.write ? cur.wdata : 32'h0, cur.write ? cur.strb : 4'h0});
                    in_xfer = 1; acc_k = 0;
                end else begin
                    if (!in_xfer) chk("access_without_setup", 1, 0);
                    oh = '0; oh[cur.sel] = 1'b1;
                    chk("access_pins", {bus.psel, bus.paddr, bus.pwrite, bus.pprot, bus.pwdata, bus.pstrb},
                        {oh, cur.addr, cur.write, cur.prot,
                         cur.write ? cur.wdata : 32'h0, cur.write ? cur.strb : 4'h0});
                    bus.pready = (acc_k >= cur.waits);
                    if (bus.pready) begin
                        bus.prdata  = cur.rdata;
                        bus.pslverr = cur.err;
                    end
                    acc_k++;
                end
            end else if (in_xfer) begin
                chk("access_len", acc_k, access_len(cur));
                chk("pins_after_xfer", {bus.penable, bus.pwdata, bus.pstrb}, 0);
                in_xfer = 0;
            end
            if (bus.rsp_valid) begin
                if (rsp_new) begin
                    if (exp_q.size() == 0) chk("unexpected_rsp", bus.rsp_valid, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("rsp_fields", {bus.rsp_rdata, bus.rsp_slverr, bus.rsp_timeout}, e.r);
                        chk("rsp_latency", cyc, e.due);
                    end
                    snap = '{rdata: bus.rsp_rdata, slverr: bus.rsp_slverr, timeout: bus.rsp_timeout};
                    rsp_new = 0;
                end else begin
                    chk("rsp_stable", {bus.rsp_rdata, bus.rsp_slverr, bus.rsp_timeout}, snap);
                end
                chk("req_ready_low_in_resp", bus.req_ready, 0);
                if (bus.rsp_ready) rsp_new = 1;
            end
        end
    end

    task automatic issue(input txn_t t, input bit expect_rsp);
        int n;
        exp_t e;
        n = 0;
        @(negedge pclk);
        bus.req_valid = 1'b1;
        bus.req_addr  = t.addr;
        bus.req_write = t.write;
        bus.req_wdata = t.wdata;
        bus.req_strb  = t.strb;
        bus.req_prot  = t.prot;
        bus.req_sel   = t.sel;
        while (!bus.req_ready && n < 300) begin
            @(negedge pclk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("req_accept_timeout", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge pclk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;
        if (sel_valid(t)) bus_q.push_back(t);
        if (expect_rsp) begin
            e.r   = model_rsp(t);
            e.due = cyc + model_lat(t);
            exp_q.push_back(e);
        end
    endtask

    function automatic txn_t mk(logic [AW-1:0] a, logic w, logic [DW-1:0] wd, logic [3:0] s,
                                logic [SW-1:0] sel, int waits, logic err, logic [DW-1:0] rd);
        txn_t t;
        t = '{addr: a, write: w, wdata: wd, strb: s, prot: 3'($urandom), sel: sel,
              waits: waits, err: err, rdata: rd};
        return t;
    endfunction

    task automatic wait_rsp_drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 400) begin
            @(negedge pclk);
            n++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    initial begin
        txn_t t;
        int   n;
        preset = 1'b1;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_wdata = '0;
        bus.req_strb = '0; bus.req_prot = '0; bus.req_sel = '0;
        #1;
        chk("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_slverr,
                              bus.rsp_timeout, bus.psel, bus.penable, bus.paddr, bus.pwrite,
                              bus.pwdata, bus.pstrb, bus.pprot}, 0);
        repeat (2) @(negedge pclk);
        #2 preset = 1'b0;
        repeat (2) @(negedge pclk);
        chk("req_ready_after_reset", bus.req_ready, 1);

        // directed: zero-wait write, 3-wait read, read error, last-cycle completion, timeout, bad select
        issue(mk(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 2'd0, 0, 1'b0, 32'h1234_5678), 1);
        wait_rsp_drain("drain_write");
        issue(mk(32'h0000_0020, 1'b0, 32'h0, 4'h0, 2'd1, 3, 1'b0, 32'hA5A5_0001), 1);
        wait_rsp_drain("drain_read_wait3");
        issue(mk(32'h0000_0030, 1'b0, 32'h0, 4'h0, 2'd2, 0, 1'b1, 32'h5555_AAAA), 1);
        wait_rsp_drain("drain_read_err");
        issue(mk(32'h0000_0040, 1'b0, 32'h0, 4'h0, 2'd0, TO - 1, 1'b0, 32'h0BAD_CAFE), 1);
        wait_rsp_drain("drain_last_cycle");
        issue(mk(32'h0000_0050, 1'b0, 32'h0, 4'h0, 2'd1, 100, 1'b0, 32'hFFFF_FFFF), 1);
        wait_rsp_drain("drain_timeout");
        issue(mk(32'h0000_0060, 1'b1, 32'h1111_2222, 4'h3, 2'd3, 0, 1'b0, 32'h0), 1);
        wait_rsp_drain("drain_bad_sel");

        // response backpressure: held 5 cycles, monitor checks stability and req_ready
        rr_mode = 2;
        issue(mk(32'h0000_0070, 1'b0, 32'h0, 4'h0, 2'd2, 1, 1'b0, 32'h7777_0007), 1);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin @(negedge pclk); n++; end
        chk("bp_rsp_seen", bus.rsp_valid, 1);
        repeat (5) @(negedge pclk);
        chk("bp_still_valid", bus.rsp_valid, 1);
        rr_mode = 0;
        wait_rsp_drain("drain_backpressure");

        // reset while waiting in ACCESS: transfer dropped, no response ever
        issue(mk(32'h0000_0080, 1'b0, 32'h0, 4'h0, 2'd1, 1000, 1'b0, 32'h0), 0);
        n = 0;
        while (!bus.penable && n < 50) begin @(negedge pclk); n++; end
        repeat (3) @(negedge pclk);
        #2 preset = 1'b1;
        #1;
        chk("mid_reset_pins", {bus.psel, bus.penable, bus.rsp_valid, bus.req_ready}, 0);
        @(negedge pclk);
        bus_q.delete();
        #2 preset = 1'b0;
        repeat (2) @(negedge pclk);
        chk("req_ready_after_mid_reset", bus.req_ready, 1);
        repeat (20) @(negedge pclk);

        // randomized traffic with random response backpressure
        rr_mode = 1;
        for (int i = 0; i < 60; i++) begin
            t = mk($urandom, 1'($urandom), $urandom, 4'($urandom),
                   (($urandom % 6) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                   (($urandom % 8) == 0) ? TO + int'($urandom % 4) : int'($urandom % 4),
                   ($urandom % 4) == 0, $urandom);
            issue(t, 1);
        end
        rr_mode = 0;
        wait_rsp_drain("drain_random");
        chk("bus_q_empty", bus_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
